reg_mux_arb: RTL and testbench
==============================

REG_MUX_ARB -- requirements
Module: reg_mux_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel in bits.
REQ-002 Parameter CHANNELS, default 32, number of input channels; SHALL be a power of two, 2..32.
REQ-003 Parameter SEL_W, default 5, select width; SHALL equal log2(CHANNELS).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 select  input  SEL_W  channel index used in mode 0; ignored in mode 1.
REQ-008 in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel data-valid.
REQ-010 in_ready  output  CHANNELS  per-channel accept strobe, combinational.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_chan  output  SEL_W  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-015 load SHALL be (!out_valid || out_ready) && (grant exists); a word is transferred on channel i when in_valid[i] && in_ready[i].
REQ-016 Mode 0: grant SHALL go to channel select iff in_valid[select]=1; otherwise no grant.
REQ-017 Mode 1: grant SHALL go to the first channel with in_valid=1 searching ptr+1, ptr+2, ... modulo CHANNELS, ending at ptr itself.
REQ-018 At most one in_ready bit SHALL be 1 per cycle; in_ready[i] = load && (grant == i).
REQ-019 On load, out_data <= granted word, out_chan <= granted index, out_valid <= 1, ptr <= granted index (both modes).
REQ-020 If out_valid && out_ready && no grant, out_valid <= 0; out_data and out_chan SHALL hold their previous values.
REQ-021 If out_valid && !out_ready, out_data, out_chan, out_valid and ptr SHALL hold; all in_ready = 0.
REQ-022 Latency input-to-output SHALL be exactly 1 cycle; sustained throughput 1 word/cycle while out_ready=1.
REQ-023 Simultaneous consume and load in the same cycle SHALL replace the word without a bubble.
REQ-024 Changes to mode or select SHALL affect only the grant decision of the current cycle; a held output word SHALL not change.
REQ-025 ptr wrap: after granting channel CHANNELS-1, the next mode 1 search SHALL start at channel 0.
REQ-026 A single requester in mode 1 SHALL be granted every cycle that load permits.

Reset
REQ-027 While reset=1: out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1, in_ready=0, regardless of clock.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; no in_ready pulse SHALL occur during reset.
REQ-029 After reset deassertion, the first mode 1 grant SHALL search from channel 0.

Verification
REQ-030 Mode 0, select=5, in_valid=all 1s, ch5=0xDEADBEEF, out_ready=1 -> next cycle out_data=0xDEADBEEF, out_chan=5, out_valid=1; only in_ready[5] pulsed.
REQ-031 Mode 1 after reset, in_valid=0x8000_0011 constant, out_ready=1 -> out_chan sequence 0,4,31,0,4,31.
REQ-032 Mode 1, out_valid=1, out_ready=0 for 3 cycles, in_valid=0xFFFF_FFFF -> out_data/out_chan frozen, in_ready=0 throughout; on out_ready=1 the next channel after the held one is loaded.
REQ-033 Mode 0, select=7, in_valid[7]=0, out_valid=1, out_ready=1 -> out_valid drops to 0 next cycle, out_data unchanged.
REQ-034 Assert reset asynchronously between edges with out_valid=1 -> out_valid, out_data, out_chan go to 0 immediately; after release with in_valid=0x4, mode 1 -> out_chan=2.
REQ-035 Parameter sweep CHANNELS=2, WIDTH=8: mode 1, both valid -> out_chan alternates 0,1,0,1 each cycle with out_ready=1.

Source files
------------

// File: rtl/reg_mux_arb.sv
// Purpose: N-channel registered mux with fixed-select or round-robin arbitration.
// Latency: 1 cycle from an accepted input word to out_data/out_valid.
// Backpressure: a held word stalls while out_ready=0, and every in_ready is 0 during that stall.
module reg_mux_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 32,
  parameter int SEL_W    = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  // Round-robin pointer: the last granted channel. It resets to the top
  // channel, so the first search after reset starts at channel 0.
  logic [SEL_W-1:0] ptr;

  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic             load;
  logic [WIDTH-1:0] chan_word [CHANNELS];

  // Unpack the flattened input bus into one word per channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan_word[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant decision. Mode 0 grants the selected channel only.
  // Mode 1 searches ptr+1 .. ptr+CHANNELS. CHANNELS is a power of two,
  // so SEL_W-bit wraparound gives the modulo, and the last candidate is ptr itself.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      grant_vld = in_valid[select];
      grant_idx = select;
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = ptr + SEL_W'(k);
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign load = (!out_valid || out_ready) && grant_vld;

  // One-hot accept strobe for the granted channel. It is gated by reset
  // so no channel sees an accept while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (load && !reset) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Output register. Load replaces the held word; a consume with no grant
  // only clears the valid flag; otherwise everything holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= chan_word[grant_idx];
      out_chan  <= grant_idx;
      ptr       <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_mux_arb.sv
// Directed bench for reg_mux_arb: a 32x32 instance plus a 2-channel 8-bit instance.
module tb_reg_mux_arb;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [4:0]    select;
  logic [1023:0] in_data;
  logic [31:0]   in_valid;
  logic [31:0]   in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic [4:0]    out_chan;
  logic          out_ready;

  logic          mode2;
  logic [0:0]    select2;
  logic [15:0]   in_data2;
  logic [1:0]    in_valid2;
  logic [1:0]    in_ready2;
  logic [7:0]    out_data2;
  logic          out_valid2;
  logic [0:0]    out_chan2;
  logic          out_ready2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_mux_arb #(.WIDTH(32), .CHANNELS(32), .SEL_W(5)) dut (
    .clock(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  reg_mux_arb #(.WIDTH(8), .CHANNELS(2), .SEL_W(1)) dut2 (
    .clock(clk), .reset(reset), .mode(mode2), .select(select2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_chan(out_chan2),
    .out_ready(out_ready2)
  );

  // Expected word of channel i in the wide instance.
  function automatic logic [31:0] word_of(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; select = 5'd5; in_valid = '1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_chan !== 5'd0) begin errors++; $display("FAIL reset_out_chan got %0d want 0", out_chan); end
    checks++; if (in_ready !== 32'h0) begin errors++; $display("FAIL reset_in_ready got %h want 0", in_ready); end
    checks++; if (in_ready2 !== 2'b00) begin errors++; $display("FAIL reset_in_ready2 got %b want 00", in_ready2); end
  endtask

  task automatic test_fixed_select();
    reset = 1'b0; mode = 1'b0; select = 5'd5; in_valid = '1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 32'h0000_0020) begin errors++; $display("FAIL fixed_in_ready got %h want 00000020", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fixed_out_data got %h want deadbeef", out_data); end
    checks++; if (out_chan !== 5'd5) begin errors++; $display("FAIL fixed_out_chan got %0d want 5", out_chan); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_out_valid got %0b want 1", out_valid); end
  endtask

  task automatic test_drop_no_grant();
    select = 5'd7; in_valid = 32'hFFFF_FF7F;
    #1;
    checks++; if (in_ready !== 32'h0) begin errors++; $display("FAIL drop_in_ready got %h want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL drop_out_data got %h want deadbeef", out_data); end
    checks++; if (out_chan !== 5'd5) begin errors++; $display("FAIL drop_out_chan got %0d want 5", out_chan); end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 4, 31, 0, 4, 31};
    reset = 1'b1; #2; reset = 1'b0;
    mode = 1'b1; in_valid = 32'h8000_0011; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++; if (in_ready !== (32'h1 << exp_seq[n])) begin errors++; $display("FAIL rr_in_ready[%0d] got %h want bit %0d", n, in_ready, exp_seq[n]); end
      @(posedge clk); #1;
      checks++; if (out_chan !== 5'(exp_seq[n])) begin errors++; $display("FAIL rr_out_chan[%0d] got %0d want %0d", n, out_chan, exp_seq[n]); end
      checks++; if (out_data !== word_of(exp_seq[n])) begin errors++; $display("FAIL rr_out_data[%0d] got %h want %h", n, out_data, word_of(exp_seq[n])); end
    end
  endtask

  task automatic test_hold_and_wrap();
    in_valid = '1; out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      // Flip mode/select mid-stall: the held word must not move.
      if (n == 1) begin mode = 1'b0; select = 5'd3; end
      if (n == 2) mode = 1'b1;
      #1;
      checks++; if (in_ready !== 32'h0) begin errors++; $display("FAIL hold_in_ready[%0d] got %h want 0", n, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_chan !== 5'd31) begin errors++; $display("FAIL hold_out_chan[%0d] got %0d want 31", n, out_chan); end
      checks++; if (out_data !== word_of(31)) begin errors++; $display("FAIL hold_out_data[%0d] got %h want %h", n, out_data, word_of(31)); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid[%0d] got %0b want 1", n, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 32'h1) begin errors++; $display("FAIL wrap_in_ready got %h want 00000001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_chan !== 5'd0) begin errors++; $display("FAIL wrap_out_chan got %0d want 0", out_chan); end
    checks++; if (out_data !== word_of(0)) begin errors++; $display("FAIL wrap_out_data got %h want %h", out_data, word_of(0)); end
    @(posedge clk); #1;
    checks++; if (out_chan !== 5'd1) begin errors++; $display("FAIL next_out_chan got %0d want 1", out_chan); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = '0;
    #2; reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL areset_out_data got %h want 0", out_data); end
    checks++; if (out_chan !== 5'd0) begin errors++; $display("FAIL areset_out_chan got %0d want 0", out_chan); end
    // While reset is held, requests must not produce an accept strobe.
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 32'h0) begin errors++; $display("FAIL areset_in_ready got %h want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_hold_valid got %0b want 0", out_valid); end
    reset = 1'b0; in_valid = 32'h4;
    @(posedge clk); #1;
    checks++; if (out_chan !== 5'd2) begin errors++; $display("FAIL areset_first_chan got %0d want 2", out_chan); end
    checks++; if (out_data !== word_of(2)) begin errors++; $display("FAIL areset_first_data got %h want %h", out_data, word_of(2)); end
  endtask

  task automatic test_back_to_back();
    in_valid = 32'h200;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (in_ready !== 32'h200) begin errors++; $display("FAIL b2b_in_ready[%0d] got %h want 00000200", n, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_chan !== 5'd9 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out[%0d] got chan %0d valid %0b want 9 1", n, out_chan, out_valid); end
    end
    in_valid = '0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_two_channels();
    int exp_seq [4] = '{0, 1, 0, 1};
    logic [7:0] exp_dat;
    mode2 = 1'b1; in_valid2 = 2'b11; out_ready2 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_dat = (exp_seq[n] == 0) ? 8'hA0 : 8'hB1;
      @(posedge clk); #1;
      checks++; if (out_chan2 !== 1'(exp_seq[n])) begin errors++; $display("FAIL two_out_chan[%0d] got %0d want %0d", n, out_chan2, exp_seq[n]); end
      checks++; if (out_data2 !== exp_dat) begin errors++; $display("FAIL two_out_data[%0d] got %h want %h", n, out_data2, exp_dat); end
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; select = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) in_data[i*32 +: 32] = word_of(i);
    mode2 = 1'b0; select2 = '0; in_data2 = 16'hB1A0; in_valid2 = '0; out_ready2 = 1'b0;
    test_reset();
    test_fixed_select();
    test_drop_no_grant();
    test_round_robin();
    test_hold_and_wrap();
    test_async_reset();
    test_back_to_back();
    test_two_channels();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
